game_flow_ctrl: RTL and testbench

//  Game-sequencing controller for the Flappy Bird top level. Owns the IDLE/READY/PLAY/DEAD flow.

---
 rtl/game_flow_ctrl.sv | 167 ++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: IDLE/READY/PLAY/DEAD sequencer for the Flappy Bird top level.
// Debounces the flap key, gates bird/tube motion, latches crash, keeps score.
// Optional feature: define HISCORE_EN to keep a best-score register across games
// (cleared only by clr); otherwise hiscore is tied to zero.
module game_flow_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned READY_FRAMES    = 60,
  parameter int unsigned DEAD_FRAMES     = 90,
  parameter int unsigned SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               frame_tick,
  input  logic               flap_n,
  input  logic               crash,
  input  logic               score_inc,
  output logic [1:0]         state,
  output logic               run_en,
  output logic               obj_clr_n,
  output logic               flap_out,
  output logic               game_over,
  output logic               blink,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FR_MAX = (READY_FRAMES > DEAD_FRAMES) ? READY_FRAMES : DEAD_FRAMES;
  localparam int unsigned FR_W   = (FR_MAX > 0) ? $clog2(FR_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    PLAY  = 2'd2,
    DEAD  = 2'd3
  } state_t;

  state_t            cur, nxt;
  logic              sync1, sync2, db_level, db_prev;
  logic [DB_W-1:0]   db_cnt;
  logic              flap_pulse;
  logic [FR_W-1:0]   fcnt;
  logic [3:0]        blink_cnt;
  logic              run_en_d, obj_clr_n_d, flap_out_d, game_over_d;

  // Key synchroniser and stability counter; the counter restarts whenever the
  // synchronised level is about to change (sync1 differs from sync2).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      db_cnt   <= '0;
      db_level <= 1'b1;
      db_prev  <= 1'b1;
    end else begin
      sync1   <= flap_n;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync1 != sync2) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        db_level <= sync2;
      end
    end
  end

  assign flap_pulse = db_prev & ~db_level;

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cur <= IDLE;
    else      cur <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:  if (flap_pulse) nxt = READY;
      READY: if (frame_tick && (fcnt == '0 || fcnt == FR_W'(1))) nxt = PLAY;
      PLAY:  if (crash) nxt = DEAD;
      DEAD:  if (flap_pulse && fcnt == '0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output decode from the current state; registered below for a one-clk lag
  always_comb begin
    run_en_d    = (cur == PLAY);
    obj_clr_n_d = (cur != IDLE);
    flap_out_d  = (cur == PLAY) && flap_pulse;
    game_over_d = (cur == DEAD);
  end

  // Output registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      run_en    <= 1'b0;
      obj_clr_n <= 1'b0;
      flap_out  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      run_en    <= run_en_d;
      obj_clr_n <= obj_clr_n_d;
      flap_out  <= flap_out_d;
      game_over <= game_over_d;
    end
  end

  // Frame counter: loaded on entry to READY/DEAD, saturating decrement on frame_tick
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fcnt <= '0;
    end else if (cur != nxt) begin
      case (nxt)
        READY:   fcnt <= FR_W'(READY_FRAMES);
        DEAD:    fcnt <= FR_W'(DEAD_FRAMES);
        default: fcnt <= '0;
      endcase
    end else if (frame_tick && fcnt != '0 && (cur == READY || cur == DEAD)) begin
      fcnt <= fcnt - 1'b1;
    end
  end

  // Score: cleared on game start, saturating increment in PLAY unless crashing
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      score <= '0;
    end else if (cur == IDLE && nxt == READY) begin
      score <= '0;
    end else if (cur == PLAY && score_inc && !crash && score != '1) begin
      score <= score + 1'b1;
    end
  end

  // Game-over flash: toggles every 16th frame_tick while DEAD, held low elsewhere
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (cur != DEAD) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (frame_tick) begin
      blink_cnt <= blink_cnt + 1'b1;
      if (blink_cnt == 4'd15) blink <= ~blink;
    end
  end

`ifdef HISCORE_EN
  // Best score captured on the clk that enters DEAD
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hiscore <= '0;
    end else if (cur == PLAY && nxt == DEAD && score > hiscore) begin
      hiscore <= score;
    end
  end
`else
  assign hiscore = '0;
`endif

  assign state = cur;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with small timing parameters.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       frame_tick, flap_n, crash, score_inc;
  logic [1:0] state;
  logic       run_en, obj_clr_n, flap_out, game_over, blink;
  logic [7:0] score, hiscore;

  int total = 0;
  int bad   = 0;

`ifdef HISCORE_EN
  localparam bit HI_ON = 1'b1;
`else
  localparam bit HI_ON = 1'b0;
`endif

  game_flow_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .READY_FRAMES(3),
    .DEAD_FRAMES(2),
    .SCORE_W(8)
  ) dut (
    .clk(clk), .clr(clr), .frame_tick(frame_tick), .flap_n(flap_n),
    .crash(crash), .score_inc(score_inc), .state(state), .run_en(run_en),
    .obj_clr_n(obj_clr_n), .flap_out(flap_out), .game_over(game_over),
    .blink(blink), .score(score), .hiscore(hiscore)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic press();
    flap_n = 1'b0;
    repeat (10) step();
    flap_n = 1'b1;
    repeat (10) step();
  endtask

  task automatic start_play();
    press();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    total++;
    if ({state, run_en, obj_clr_n, flap_out, game_over, blink} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=%b", {state, run_en, obj_clr_n, flap_out, game_over, blink}, 7'b0);
    end
    total++;
    if ({score, hiscore} !== 16'h0) begin
      bad++;
      $display("FAIL reset_score got=%h exp=%h", {score, hiscore}, 16'h0);
    end
  endtask

  task automatic test_bounce();
    score_inc = 1'b1;
    crash     = 1'b1;
    step();
    score_inc = 1'b0;
    crash     = 1'b0;
    flap_n = 1'b0;
    repeat (3) step();
    flap_n = 1'b1;
    repeat (12) step();
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL bounce_state got=%0d exp=%0d", state, 0);
    end
    total++;
    if (score !== 8'd0) begin
      bad++;
      $display("FAIL idle_score_ignored got=%0d exp=%0d", score, 0);
    end
  endtask

  task automatic test_press_ready();
    flap_n = 1'b0;
    repeat (6) step();
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL press_early got=%0d exp=%0d", state, 0);
    end
    step();
    total++;
    if (state !== 2'd1 || obj_clr_n !== 1'b0) begin
      bad++;
      $display("FAIL press_ready got=%0d/%b exp=1/0", state, obj_clr_n);
    end
    step();
    total++;
    if (obj_clr_n !== 1'b1 || run_en !== 1'b0) begin
      bad++;
      $display("FAIL ready_outputs got=%b%b exp=10", obj_clr_n, run_en);
    end
    flap_n = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_ready_to_play();
    tick();
    tick();
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL ready_hold got=%0d exp=%0d", state, 1);
    end
    tick();
    total++;
    if (state !== 2'd2 || run_en !== 1'b0) begin
      bad++;
      $display("FAIL play_entry got=%0d/%b exp=2/0", state, run_en);
    end
    step();
    total++;
    if (run_en !== 1'b1) begin
      bad++;
      $display("FAIL play_run_en got=%b exp=1", run_en);
    end
  endtask

  task automatic test_flap_out();
    flap_n = 1'b0;
    repeat (7) step();
    total++;
    if (flap_out !== 1'b1) begin
      bad++;
      $display("FAIL flap_out_high got=%b exp=1", flap_out);
    end
    step();
    total++;
    if (flap_out !== 1'b0) begin
      bad++;
      $display("FAIL flap_out_low got=%b exp=0", flap_out);
    end
    flap_n = 1'b1;
    repeat (10) step();
  endtask

  task automatic add_points(input int n);
    for (int i = 0; i < n; i++) begin
      score_inc = 1'b1;
      step();
      score_inc = 1'b0;
      step();
    end
  endtask

  task automatic crash_now();
    crash     = 1'b1;
    score_inc = 1'b1;
    step();
    crash     = 1'b0;
    score_inc = 1'b0;
  endtask

  task automatic test_score_crash();
    add_points(5);
    total++;
    if (score !== 8'd5) begin
      bad++;
      $display("FAIL score_five got=%0d exp=%0d", score, 5);
    end
    crash_now();
    total++;
    if (state !== 2'd3 || score !== 8'd5) begin
      bad++;
      $display("FAIL crash_wins got=%0d/%0d exp=3/5", state, score);
    end
    step();
    total++;
    if (game_over !== 1'b1 || run_en !== 1'b0 || obj_clr_n !== 1'b1) begin
      bad++;
      $display("FAIL dead_outputs got=%b%b%b exp=101", game_over, run_en, obj_clr_n);
    end
    total++;
    if (hiscore !== (HI_ON ? 8'd5 : 8'd0)) begin
      bad++;
      $display("FAIL hiscore_game1 got=%0d exp=%0d", hiscore, HI_ON ? 5 : 0);
    end
  endtask

  task automatic test_dead_flap();
    press();
    total++;
    if (state !== 2'd3) begin
      bad++;
      $display("FAIL dead_early_flap got=%0d exp=%0d", state, 3);
    end
    tick();
    tick();
    press();
    total++;
    if (state !== 2'd0 || obj_clr_n !== 1'b0 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL dead_restart got=%0d/%b/%b exp=0/0/0", state, obj_clr_n, game_over);
    end
  endtask

  task automatic test_second_game();
    press();
    total++;
    if (state !== 2'd1 || score !== 8'd0) begin
      bad++;
      $display("FAIL game2_start got=%0d/%0d exp=1/0", state, score);
    end
    repeat (3) tick();
    add_points(3);
    crash_now();
    step();
    total++;
    if (score !== 8'd3 || hiscore !== (HI_ON ? 8'd5 : 8'd0)) begin
      bad++;
      $display("FAIL hiscore_game2 got=%0d/%0d exp=3/%0d", score, hiscore, HI_ON ? 5 : 0);
    end
    tick();
    tick();
    press();
  endtask

  task automatic test_saturation();
    start_play();
    score_inc = 1'b1;
    repeat (255) step();
    score_inc = 1'b0;
    total++;
    if (score !== 8'd255) begin
      bad++;
      $display("FAIL score_max got=%0d exp=%0d", score, 255);
    end
    add_points(3);
    total++;
    if (score !== 8'd255) begin
      bad++;
      $display("FAIL score_saturate got=%0d exp=%0d", score, 255);
    end
    crash_now();
    step();
    total++;
    if (hiscore !== (HI_ON ? 8'd255 : 8'd0)) begin
      bad++;
      $display("FAIL hiscore_game3 got=%0d exp=%0d", hiscore, HI_ON ? 255 : 0);
    end
  endtask

  task automatic test_blink();
    repeat (15) tick();
    total++;
    if (blink !== 1'b0) begin
      bad++;
      $display("FAIL blink_before got=%b exp=0", blink);
    end
    tick();
    total++;
    if (blink !== 1'b1) begin
      bad++;
      $display("FAIL blink_toggle got=%b exp=1", blink);
    end
    press();
    total++;
    if (state !== 2'd0 || blink !== 1'b0) begin
      bad++;
      $display("FAIL blink_cleared got=%0d/%b exp=0/0", state, blink);
    end
  endtask

  task automatic test_clr_mid();
    start_play();
    add_points(2);
    total++;
    if (state !== 2'd2 || score !== 8'd2) begin
      bad++;
      $display("FAIL clr_setup got=%0d/%0d exp=2/2", state, score);
    end
    #2;
    clr = 1'b0;
    #1;
    total++;
    if ({state, run_en, obj_clr_n, flap_out, game_over, blink, score, hiscore} !== 23'b0) begin
      bad++;
      $display("FAIL clr_mid got=%0d/%b%b%b%b%b/%0d/%0d exp=all zero", state, run_en, obj_clr_n,
               flap_out, game_over, blink, score, hiscore);
    end
    step();
    clr = 1'b1;
    step();
  endtask

  initial begin
    clr        = 1'b0;
    frame_tick = 1'b0;
    flap_n     = 1'b1;
    crash      = 1'b0;
    score_inc  = 1'b0;
    repeat (2) step();
    test_reset();
    clr = 1'b1;
    step();
    test_bounce();
    test_press_ready();
    test_ready_to_play();
    test_flap_out();
    test_score_crash();
    test_dead_flap();
    test_second_game();
    test_saturation();
    test_blink();
    test_clr_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
